// File: rtl/pe_array_pkg.sv
// Shared constants, FSM state type and final-beat helper for the PE result serializer.
// Build option: define SERIALIZER_CHECKSUM_EN to append an XOR checksum beat to each frame.
package pe_array_pkg;

    localparam int NUM_PE     = 25;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic {
        IDLE,
        STREAM
    } ser_state_t;

    // Index of the beat that carries out_last; the checksum beat follows word NUM_PE-1.
    function automatic logic [ADDR_WIDTH-1:0] final_beat_idx();
`ifdef SERIALIZER_CHECKSUM_EN
        return ADDR_WIDTH'(NUM_PE);
`else
        return ADDR_WIDTH'(NUM_PE - 1);
`endif
    endfunction

endpackage

// File: rtl/pe_snapshot_bank.sv
// Snapshot of all PE output words, captured together in one cycle and read back by index.
// Build option: SERIALIZER_CHECKSUM_EN makes index NUM_PE return the XOR of all words.
module pe_snapshot_bank
    import pe_array_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         capture,
    input  logic [NUM_PE*DATA_WIDTH-1:0] data_flat,
    input  logic [ADDR_WIDTH-1:0]        rd_idx,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    logic [DATA_WIDTH-1:0] snap [NUM_PE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PE; i++) begin
                snap[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_PE; i++) begin
                snap[i] <= data_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef SERIALIZER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;

    always_comb begin
        checksum = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            checksum = checksum ^ snap[i];
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (rd_idx < ADDR_WIDTH'(NUM_PE)) begin
            rd_data = snap[rd_idx];
        end
`ifdef SERIALIZER_CHECKSUM_EN
        else begin
            rd_data = checksum;
        end
`endif
    end

endmodule

// File: rtl/pe_result_serializer.sv
// Captures the 25 PE outputs on frame_done and streams them out over valid/ready with a last flag.
// Build option: SERIALIZER_CHECKSUM_EN adds a trailing XOR checksum beat that carries out_last.
module pe_result_serializer
    import pe_array_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe_data_flat,
    input  logic                         frame_done,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = final_beat_idx();

    ser_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0] idx, idx_next;
    logic                  capture;
    logic                  drop;
    logic [DATA_WIDTH-1:0] rd_data;

    pe_snapshot_bank u_bank (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .data_flat (pe_data_flat),
        .rd_idx    (idx),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // A frame_done landing on the final-beat handshake chains straight into the next frame.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_done) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (out_ready && idx == LAST_IDX) begin
                    idx_next = '0;
                    if (frame_done) begin
                        capture = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (out_ready) begin
                        idx_next = idx + 1'b1;
                    end
                    if (frame_done) begin
                        drop = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_last  = (state == STREAM) && (idx == LAST_IDX);
    assign out_data  = (state == STREAM) ? rd_data : '0;

endmodule

// File: tb/tb_pe_result_serializer.sv
// Self-checking bench for pe_result_serializer: table-driven frames plus hand-written corner sequences.
// Honours SERIALIZER_CHECKSUM_EN to expect the extra checksum beat.
module tb_pe_result_serializer;

    localparam int NPE = 25;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int FINAL = 25;
`else
    localparam int FINAL = 24;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] base;
        logic [3:0] ready_pat;
        logic [7:0] exp_first;
        logic [7:0] exp_xor;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [NPE*8-1:0] pe_data_flat;
    logic           frame_done;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           busy;
    logic           overflow;

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] rx_xor;
    int         rx_count;
    vec_t       vecs[4];

    always #5 clk = ~clk;

    pe_result_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .pe_data_flat (pe_data_flat),
        .frame_done   (frame_done),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .overflow     (overflow)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_pe(input logic [7:0] base);
        for (int i = 0; i < NPE; i++) pe_data_flat[i*8 +: 8] = 8'(base + i);
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < NPE; i++) begin
            beat_t b;
            b.data = 8'(base + i);
`ifdef SERIALIZER_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = 1'(i == NPE - 1);
`endif
            sb.push_back(b);
        end
`ifdef SERIALIZER_CHECKSUM_EN
        begin
            beat_t c;
            c.data = '0;
            for (int i = 0; i < NPE; i++) c.data = c.data ^ 8'(base + i);
            c.last = 1'b1;
            sb.push_back(c);
        end
`endif
    endtask

    // Scoreboard pop on handshakes, plus hold-stable checks across stall cycles.
    task automatic sample_outputs();
        if (out_valid) begin
            if (prev_stall) begin
                check_output("hold_data", out_data, prev_data);
                check_output("hold_last", out_last, prev_last);
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check_output("beat_data", out_data, e.data);
                    check_output("beat_last", out_last, e.last);
                end
                if (rx_count < NPE) rx_xor = rx_xor ^ out_data;
                rx_count++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end else begin
            if (prev_stall) begin
                checks++;
                errors++;
                $display("[TB] FAIL valid_dropped: got out_valid 0, expected 1");
            end
            prev_stall = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_outputs();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus_frame(input logic [7:0] base);
        set_pe(base);
        rx_xor   = '0;
        rx_count = 0;
        push_frame(base);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic drain(input logic [3:0] pat, output int n);
        bit idle_seen = 1'b0;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = pat[c % 4];
            tick();
            n++;
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        if (!idle_seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got busy 1, expected 0 within 400 cycles");
        end
        check_output("queue_empty", sb.size(), 0);
    endtask

    initial begin
        int  n;
        bit  found;

        vecs[0] = '{base: 8'h00, ready_pat: 4'b1111, exp_first: 8'h00, exp_xor: 8'h18};
        vecs[1] = '{base: 8'h00, ready_pat: 4'b1001, exp_first: 8'h00, exp_xor: 8'h18};
        vecs[2] = '{base: 8'h40, ready_pat: 4'b0101, exp_first: 8'h40, exp_xor: 8'h58};
        vecs[3] = '{base: 8'h80, ready_pat: 4'b1111, exp_first: 8'h80, exp_xor: 8'h98};

        reset        = 1'b1;
        frame_done   = 1'b0;
        out_ready    = 1'b0;
        pe_data_flat = '0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        rx_xor       = '0;
        rx_count     = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", out_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_last", out_last, 0);
        check_output("rst_data", out_data, 0);
        reset = 1'b0;
        tick();

        // Table-driven frames with varying backpressure patterns.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus_frame(vecs[k].base);
            check_output("first_valid", out_valid, 1);
            check_output("first_data", out_data, vecs[k].exp_first);
            drain(vecs[k].ready_pat, n);
            check_output("frame_xor", rx_xor, vecs[k].exp_xor);
            check_output("frame_beats", rx_count, FINAL + 1);
            if (vecs[k].ready_pat == 4'b1111) check_output("frame_cycles", n, FINAL + 1);
            check_output("table_overflow", overflow, 0);
        end

        // Dropped frame_done mid-stream: original words continue, overflow sticks.
        apply_stimulus_frame(8'h00);
        out_ready = 1'b1;
        repeat (10) tick();
        check_output("ovf_beat10", out_data, 8'h0A);
        for (int i = 0; i < NPE; i++) pe_data_flat[i*8 +: 8] = 8'hFF;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check_output("ovf_set", overflow, 1);
        drain(4'b1111, n);
        repeat (3) tick();
        check_output("ovf_sticky", overflow, 1);
        check_output("ovf_idle", busy, 0);

        // Reset asserted while beat 12 is stalled.
        apply_stimulus_frame(8'h40);
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (out_valid && out_data == 8'h4C) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_output("reach_beat12", found, 1);
        out_ready = 1'b0;
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        check_output("arst_valid", out_valid, 0);
        check_output("arst_busy", busy, 0);
        check_output("arst_overflow", overflow, 0);
        check_output("arst_last", out_last, 0);
        check_output("arst_data", out_data, 0);
        prev_stall = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // frame_done while idle with the consumer stalled for five cycles.
        out_ready = 1'b0;
        apply_stimulus_frame(8'h80);
        for (int c = 0; c < 5; c++) begin
            check_output("stall_valid", out_valid, 1);
            check_output("stall_data", out_data, 8'h80);
            check_output("stall_busy", busy, 1);
            tick();
        end
        drain(4'b1111, n);
        check_output("stall_beats", rx_count, FINAL + 1);

        // frame_done on the final-beat handshake chains without a gap.
        apply_stimulus_frame(8'h00);
        out_ready = 1'b1;
        repeat (FINAL) tick();
        check_output("chain_last", out_last, 1);
        set_pe(8'h80);
        push_frame(8'h80);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check_output("chain_valid", out_valid, 1);
        check_output("chain_data", out_data, 8'h80);
        check_output("chain_overflow", overflow, 0);
        drain(4'b1111, n);
        check_output("chain_overflow_end", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
